// File: rtl/alu_output_register_stage.sv
// alu_output_register_stage
// Output stage behind the 54-bit, 3-segment SIMD ALU.
// - Registers the ALU sum and the per-segment carry-outs.
// - Produces masked pattern and pattern-bar detects per segment.
// - Produces full-width accumulate overflow/underflow pulses.
// PREG=1 registers everything (latency 1). PREG=0 passes S and the detects
// straight through; only the detect history is clocked in that case.
// P_WIDTH is expected to equal 3*SEG_WIDTH.
// Optional build macro ALU_OUT_AUTORESET_EN: P/CARRYOUT clear on the edge
// after a detect (per segment in SIMD mode), for count-to-terminal
// accumulators. It applies to the registered build only.
module alu_output_register_stage #(
    parameter int P_WIDTH   = 54,
    parameter int SEG_WIDTH = 18,
    parameter int PREG      = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CEP,
    input  logic               USE_SIMD,
    input  logic [P_WIDTH-1:0] S,
    input  logic [5:0]         carry_in,
    input  logic [P_WIDTH-1:0] PATTERN,
    input  logic [P_WIDTH-1:0] MASK,
    output logic [P_WIDTH-1:0] P,
    output logic [5:0]         CARRYOUT,
    output logic [2:0]         PATTERNDETECT,
    output logic [2:0]         PATTERNBDETECT,
    output logic               OVERFLOW,
    output logic               UNDERFLOW
);

    // Per-segment masked equality; a MASK bit of 1 forces that bit to match.
    function automatic logic [2:0] seg_match(
        input logic [P_WIDTH-1:0] val,
        input logic [P_WIDTH-1:0] pat,
        input logic [P_WIDTH-1:0] msk
    );
        logic [P_WIDTH-1:0] hit;
        logic [2:0]         res;
        hit = (val ~^ pat) | msk;
        for (int k = 0; k < 3; k++) begin
            res[k] = &hit[k*SEG_WIDTH +: SEG_WIDTH];
        end
        return res;
    endfunction

    // A previously matching value that now matches neither pattern nor bar
    // has left the representable window: that is the flow event.
    function automatic logic flow_flag(
        input logic hist,
        input logic pd_now,
        input logic pdb_now,
        input logic enable
    );
        return enable & hist & ~pd_now & ~pdb_now;
    endfunction

    // ---- stage p0: combinational detect and flag evaluation ----
    logic       use_simd_p0;
    logic [2:0] m_p0;
    logic [2:0] mb_p0;
    logic [2:0] pd_p0;
    logic [2:0] pdb_p0;
    logic       mode_chg_p0;
    logic       flow_en_p0;
    logic       ov_p0;
    logic       uf_p0;

    // History of the last accepted detect, plus the mode it was taken in.
    logic use_simd_q;
    logic pd_hist;
    logic pdb_hist;

    // An X on USE_SIMD must not spread into the detect outputs: only a
    // clean 1 selects SIMD mode.
    assign use_simd_p0 = (USE_SIMD === 1'b1);

    assign m_p0  = seg_match(S, PATTERN, MASK);
    assign mb_p0 = seg_match(S, ~PATTERN, MASK);

    // Fold the segment matches into one word-wide detect outside SIMD mode.
    always_comb begin
        pd_p0  = m_p0;
        pdb_p0 = mb_p0;
        if (!use_simd_p0) begin
            pd_p0  = {3{&m_p0}};
            pdb_p0 = {3{&mb_p0}};
        end
    end

    // A mode switch invalidates the history, so no flag may fire on it.
    assign mode_chg_p0 = (use_simd_p0 != use_simd_q);
    assign flow_en_p0  = ~use_simd_p0 & ~mode_chg_p0;
    assign ov_p0       = flow_flag(pd_hist,  pd_p0[0], pdb_p0[0], flow_en_p0);
    assign uf_p0       = flow_flag(pdb_hist, pd_p0[0], pdb_p0[0], flow_en_p0);

    // Detect history and mode copy; clocked in both PREG builds.
    always_ff @(posedge clk) begin
        if (reset) begin
            use_simd_q <= 1'b0;
            pd_hist    <= 1'b0;
            pdb_hist   <= 1'b0;
        end else if (CEP) begin
            use_simd_q <= use_simd_p0;
            if (mode_chg_p0) begin
                pd_hist  <= 1'b0;
                pdb_hist <= 1'b0;
            end else begin
                pd_hist  <= pd_p0[0];
                pdb_hist <= pdb_p0[0];
            end
        end
    end

    if (PREG != 0) begin : g_reg
        // ---- stage p1: registered outputs ----
        logic [P_WIDTH-1:0] p_p1;
        logic [5:0]         cy_p1;
        logic [2:0]         pd_p1;
        logic [2:0]         pdb_p1;
        logic               ov_p1;
        logic               uf_p1;
        logic [P_WIDTH-1:0] p_load_p0;
        logic [5:0]         cy_load_p0;

`ifdef ALU_OUT_AUTORESET_EN
        logic [2:0] ar_seg_p0;

        // Zero the segments whose detect fired on the previous edge.
        always_comb begin
            ar_seg_p0  = use_simd_p0 ? pd_p1 : {3{pd_p1[0]}};
            p_load_p0  = S;
            cy_load_p0 = carry_in;
            for (int k = 0; k < 3; k++) begin
                if (ar_seg_p0[k]) begin
                    p_load_p0[k*SEG_WIDTH +: SEG_WIDTH] = '0;
                    cy_load_p0[2*k +: 2]                = 2'b00;
                end
            end
        end
`else
        assign p_load_p0  = S;
        assign cy_load_p0 = carry_in;
`endif

        // Output register; reset wins over the clock enable.
        always_ff @(posedge clk) begin
            if (reset) begin
                p_p1   <= '0;
                cy_p1  <= '0;
                pd_p1  <= '0;
                pdb_p1 <= '0;
                ov_p1  <= 1'b0;
                uf_p1  <= 1'b0;
            end else if (CEP) begin
                p_p1   <= p_load_p0;
                cy_p1  <= cy_load_p0;
                pd_p1  <= pd_p0;
                pdb_p1 <= pdb_p0;
                ov_p1  <= ov_p0;
                uf_p1  <= uf_p0;
            end
        end

        assign P              = p_p1;
        assign CARRYOUT       = cy_p1;
        assign PATTERNDETECT  = pd_p1;
        assign PATTERNBDETECT = pdb_p1;
        assign OVERFLOW       = ov_p1;
        assign UNDERFLOW      = uf_p1;
    end else begin : g_bypass
        // ---- stage p0 drives the outputs directly ----
        assign P              = S;
        assign CARRYOUT       = carry_in;
        assign PATTERNDETECT  = pd_p0;
        assign PATTERNBDETECT = pdb_p0;
        assign OVERFLOW       = ov_p0;
        assign UNDERFLOW      = uf_p0;
    end

endmodule

// File: tb/tb_alu_output_register_stage.sv
// Directed bench for alu_output_register_stage (default PREG=1).
module tb_alu_output_register_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        CEP;
    logic        USE_SIMD;
    logic [53:0] S;
    logic [5:0]  carry_in;
    logic [53:0] PATTERN;
    logic [53:0] MASK;
    logic [53:0] P;
    logic [5:0]  CARRYOUT;
    logic [2:0]  PATTERNDETECT;
    logic [2:0]  PATTERNBDETECT;
    logic        OVERFLOW;
    logic        UNDERFLOW;

    int total = 0;
    int bad   = 0;

    alu_output_register_stage dut (
        .clk           (clk),
        .reset         (reset),
        .CEP           (CEP),
        .USE_SIMD      (USE_SIMD),
        .S             (S),
        .carry_in      (carry_in),
        .PATTERN       (PATTERN),
        .MASK          (MASK),
        .P             (P),
        .CARRYOUT      (CARRYOUT),
        .PATTERNDETECT (PATTERNDETECT),
        .PATTERNBDETECT(PATTERNBDETECT),
        .OVERFLOW      (OVERFLOW),
        .UNDERFLOW     (UNDERFLOW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        simd;
        logic [53:0] s;
        logic [5:0]  cy;
        logic [53:0] pat;
        logic [53:0] msk;
        logic [2:0]  pd;
        logic [2:0]  pdb;
        logic        ov;
        logic        uf;
    } vec_t;

    localparam logic [53:0] ALL1 = {54{1'b1}};
    localparam logic [53:0] TOPM = {2'b00, {52{1'b1}}};
    localparam logic [53:0] T10  = {2'b10, 52'h0};
    localparam logic [53:0] T11  = {2'b11, 52'h0};
    localparam logic [53:0] T01  = {2'b01, 52'h0};

    vec_t tbl[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Sequential table: flag expectations depend on the previous row.
        tbl[0]  = '{1'b0, 54'h1234, 6'h15, 54'h0, ALL1, 3'b111, 3'b111, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 54'h0,    6'h01, 54'h0, 54'h0, 3'b111, 3'b000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, T10,      6'h2A, 54'h0, TOPM, 3'b000, 3'b000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, T10,      6'h2B, 54'h0, TOPM, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, T11,      6'h04, 54'h0, TOPM, 3'b000, 3'b111, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, T01,      6'h05, 54'h0, TOPM, 3'b000, 3'b000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, T01,      6'h06, 54'h0, TOPM, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, {18'h1, 18'h0, 18'h5}, 6'h07, 54'h0, 54'h0, 3'b010, 3'b000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, {18'h3FFFF, 18'h0, 18'h2}, 6'h08, 54'h0, 54'h0, 3'b010, 3'b100, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, {18'h5, 18'h6, 18'h8}, 6'h09, {18'h5, 18'h6, 18'h7}, 54'h0, 3'b110, 3'b000, 1'b0, 1'b0};
        tbl[10] = '{1'b1, {18'h5, 18'h6, 18'h8}, 6'h0A, {18'h5, 18'h6, 18'h7}, {36'h0, 18'hF}, 3'b111, 3'b000, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 54'h55,   6'h0B, 54'h55, 54'h0, 3'b111, 3'b000, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 54'h0,    6'h0C, 54'h0, ALL1, 3'b111, 3'b111, 1'b0, 1'b0};
        tbl[13] = '{1'b0, {18'h1, 18'h0, 18'h5}, 6'h0D, 54'h0, 54'h0, 3'b000, 3'b000, 1'b1, 1'b1};

        // Reset with CEP high: everything reads zero.
        reset = 1'b1; CEP = 1'b1; USE_SIMD = 1'b0;
        S = 54'h1234; carry_in = 6'h3F; PATTERN = 54'h0; MASK = 54'h0;
        step();
        step();
        chk("rst_P", 64'(P), 64'h0);
        chk("rst_CY", 64'(CARRYOUT), 64'h0);
        chk("rst_PD", 64'(PATTERNDETECT), 64'h0);
        chk("rst_PDB", 64'(PATTERNBDETECT), 64'h0);
        chk("rst_OV", 64'(OVERFLOW), 64'h0);
        chk("rst_UF", 64'(UNDERFLOW), 64'h0);

        // First load one cycle after reset release.
        reset = 1'b0;
        step();
        chk("load_P", 64'(P), 64'h1234);
        chk("load_CY", 64'(CARRYOUT), 64'h3F);
        chk("load_PD", 64'(PATTERNDETECT), 64'h0);

        // CEP low: outputs hold while inputs move (inputs would detect).
        CEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            S = 54'h777 + 54'(i); carry_in = 6'(i); PATTERN = S;
            step();
            chk($sformatf("hold%0d_P", i), 64'(P), 64'h1234);
            chk($sformatf("hold%0d_CY", i), 64'(CARRYOUT), 64'h3F);
            chk($sformatf("hold%0d_PD", i), 64'(PATTERNDETECT), 64'h0);
            chk($sformatf("hold%0d_OV", i), 64'(OVERFLOW), 64'h0);
        end
        CEP = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            USE_SIMD = tbl[i].simd; S = tbl[i].s; carry_in = tbl[i].cy;
            PATTERN = tbl[i].pat; MASK = tbl[i].msk;
            step();
            chk($sformatf("row%0d_P", i), 64'(P), 64'(tbl[i].s));
            chk($sformatf("row%0d_CY", i), 64'(CARRYOUT), 64'(tbl[i].cy));
            chk($sformatf("row%0d_PD", i), 64'(PATTERNDETECT), 64'(tbl[i].pd));
            chk($sformatf("row%0d_PDB", i), 64'(PATTERNBDETECT), 64'(tbl[i].pdb));
            chk($sformatf("row%0d_OV", i), 64'(OVERFLOW), 64'(tbl[i].ov));
            chk($sformatf("row%0d_UF", i), 64'(UNDERFLOW), 64'(tbl[i].uf));
        end

        // Terminal count: S hits PATTERN, then the next load.
        USE_SIMD = 1'b0; MASK = 54'h0; PATTERN = 54'd10; S = 54'd10; carry_in = 6'h3;
        step();
        chk("term_P", 64'(P), 64'd10);
        chk("term_PD", 64'(PATTERNDETECT), 64'h7);
        S = 54'd7;
        step();
`ifdef ALU_OUT_AUTORESET_EN
        chk("after_P", 64'(P), 64'h0);
        chk("after_CY", 64'(CARRYOUT), 64'h0);
`else
        chk("after_P", 64'(P), 64'd7);
        chk("after_CY", 64'(CARRYOUT), 64'h3);
`endif
        chk("after_PD", 64'(PATTERNDETECT), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
